// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for EX: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, with sign fix-up on the way out.
module ex_muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            md_start,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] md_s1,
   input  logic [XLEN-1:0] md_s2,
   input  logic            md_flush,
   output logic            md_stall,
   output logic            md_done,
   output logic [XLEN-1:0] md_result,
   output logic            md_busy
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      op;
   logic            sign1, sign2;
   logic [XLEN-1:0] acc, mq, mplier, rem, q;

   function automatic logic [XLEN-1:0] neg_if(input logic signed [XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_if_wide(input logic signed [2*XLEN-1:0] v,
                                                     input logic neg);
      return neg ? -v : v;
   endfunction

   logic            s1_sgn, s2_sgn, neg1, neg2, div0, ovf;
   logic [XLEN-1:0] spec_res;

   always_comb begin
      s1_sgn   = (md_op == 3'd1) | (md_op == 3'd2) | (md_op == 3'd4) | (md_op == 3'd6);
      s2_sgn   = (md_op == 3'd1) | (md_op == 3'd4) | (md_op == 3'd6);
      neg1     = s1_sgn & md_s1[XLEN-1];
      neg2     = s2_sgn & md_s2[XLEN-1];
      div0     = (md_s2 == '0);
      ovf      = md_op[2] & ~md_op[0] & (md_s1 == MIN_NEG) & (&md_s2);
      // REM/REMU have op[1] set; quotient ops take the all-ones / MIN_NEG special values
      spec_res = md_op[1] ? (div0 ? md_s1 : '0) : (div0 ? '1 : MIN_NEG);
   end

   logic [XLEN:0]     add, rem_sh, trial;
   logic [XLEN-1:0]   acc_nxt, mq_nxt, rem_nxt, q_nxt, mul_res, div_res;
   logic [2*XLEN-1:0] prod;
   logic              keep;

   always_comb begin
      add     = {1'b0, acc} + (mq[0] ? {1'b0, mplier} : '0);
      acc_nxt = add[XLEN:1];
      mq_nxt  = {add[0], mq[XLEN-1:1]};
      prod    = neg_if_wide({acc_nxt, mq_nxt}, sign1 ^ sign2);
      mul_res = (op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

      // remainder stays below the divisor, so the extra bit only carries the borrow
      rem_sh  = {rem, q[XLEN-1]};
      trial   = rem_sh - {1'b0, mplier};
      keep    = ~trial[XLEN];
      rem_nxt = keep ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
      q_nxt   = {q[XLEN-2:0], keep};
      div_res = op[1] ? neg_if(rem_nxt, sign1) : neg_if(q_nxt, sign1 ^ sign2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         op        <= '0;
         sign1     <= 1'b0;
         sign2     <= 1'b0;
         acc       <= '0;
         mq        <= '0;
         mplier    <= '0;
         rem       <= '0;
         q         <= '0;
         md_done   <= 1'b0;
         md_result <= '0;
      end else begin
         md_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (md_start && !md_flush) begin
                  op     <= md_op;
                  sign1  <= neg1;
                  sign2  <= neg2;
                  cnt    <= '0;
                  acc    <= '0;
                  rem    <= '0;
                  mq     <= neg_if(md_s1, neg1);
                  q      <= neg_if(md_s1, neg1);
                  mplier <= neg_if(md_s2, neg2);
                  if (!md_op[2]) begin
                     state <= S_MUL;
                  end else if (div0 || ovf) begin
                     md_result <= spec_res;
                     md_done   <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     state <= S_DIV;
                  end
               end
            end
            S_MUL: begin
               if (md_flush) begin
                  state <= S_IDLE;
               end else begin
                  acc <= acc_nxt;
                  mq  <= mq_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(XLEN-1)) begin
                     md_result <= mul_res;
                     md_done   <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end
            S_DIV: begin
               if (md_flush) begin
                  state <= S_IDLE;
               end else begin
                  rem <= rem_nxt;
                  q   <= q_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(XLEN-1)) begin
                     md_result <= div_res;
                     md_done   <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign md_busy  = (state != S_IDLE);
   assign md_stall = ~rst & (((state == S_IDLE) & md_start & ~md_flush) |
                             (state == S_MUL) | (state == S_DIV));

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: latency, stall window, signed results, special
// divides, flush, async reset and back-to-back issue.
module tb_ex_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        md_start = 1'b0;
   logic [2:0]  md_op = '0;
   logic [31:0] md_s1 = '0;
   logic [31:0] md_s2 = '0;
   logic        md_flush = 1'b0;
   logic        md_stall, md_done, md_busy;
   logic [31:0] md_result;

   int checks = 0;
   int failures = 0;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3,
                          OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   ex_muldiv_seq #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op), .md_s1(md_s1),
      .md_s2(md_s2), .md_flush(md_flush), .md_stall(md_stall), .md_done(md_done),
      .md_result(md_result), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op from an IDLE cycle; return at the done cycle (lat = cycles after accept).
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int lat, output int stl, output logic [31:0] res);
      md_op = op; md_s1 = a; md_s2 = b; md_start = 1'b1;
      #1;
      stl = md_stall ? 1 : 0;
      @(posedge clk);
      #1;
      if (!hold) md_start = 1'b0;
      else md_s1 = ~a;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         if (md_stall) stl++;
         if (md_done) begin
            lat = k;
            break;
         end
         step();
      end
      res = md_result;
      md_start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", md_busy); end
      checks++; if (md_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", md_done); end
      checks++; if (md_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b want=0", md_stall); end
      checks++; if (md_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", md_result); end
      step(); step();
      #3 rst = 1'b0;
      step();
   endtask

   task automatic test_mul();
      int lat, stl; logic [31:0] res;
      do_op(OP_MUL, 32'd7, 32'd6, 1'b0, lat, stl, res);
      checks++; if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d want=33", lat); end
      checks++; if (stl !== 33) begin failures++; $display("FAIL mul_stall_cycles got=%0d want=33", stl); end
      checks++; if (res !== 32'd42) begin failures++; $display("FAIL mul_result got=%h want=%h", res, 32'd42); end
      checks++; if (md_stall !== 1'b0) begin failures++; $display("FAIL mul_stall_in_done got=%0b want=0", md_stall); end
      step();
      checks++; if (md_done !== 1'b0 || md_busy !== 1'b0) begin failures++; $display("FAIL mul_done_pulse done=%0b busy=%0b want=0,0", md_done, md_busy); end
      checks++; if (md_result !== 32'd42) begin failures++; $display("FAIL mul_result_hold got=%h want=%h", md_result, 32'd42); end
   endtask

   task automatic test_mulh();
      int lat, stl; logic [31:0] res;
      do_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, stl, res);
      checks++; if (res !== 32'h0 || lat !== 33) begin failures++; $display("FAIL mulh_m1_m1 got=%h lat=%0d want=00000000 lat=33", res, lat); end
      step();
      do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, stl, res);
      checks++; if (res !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu_max got=%h want=fffffffe", res); end
      step();
      do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, stl, res);
      checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu_m1_2 got=%h want=ffffffff", res); end
      step();
      do_op(OP_MUL, 32'hFFFF_FFF9, 32'd3, 1'b0, lat, stl, res);
      checks++; if (res !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_neg got=%h want=ffffffeb", res); end
      step();
   endtask

   task automatic test_div();
      int lat, stl; logic [31:0] res;
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, stl, res);
      checks++; if (res !== 32'hFFFF_FFFD || lat !== 33) begin failures++; $display("FAIL div_m7_2 got=%h lat=%0d want=fffffffd lat=33", res, lat); end
      step();
      do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, stl, res);
      checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_m7_2 got=%h want=ffffffff", res); end
      step();
      do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, stl, res);
      checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%h want=%h", res, 32'd14); end
      step();
      do_op(OP_REMU, 32'd100, 32'd7, 1'b0, lat, stl, res);
      checks++; if (res !== 32'd2) begin failures++; $display("FAIL remu_100_7 got=%h want=%h", res, 32'd2); end
      step();
      do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, stl, res);
      checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_7_m2 got=%h want=fffffffd", res); end
      step();
   endtask

   task automatic test_special();
      int lat, stl; logic [31:0] res;
      do_op(OP_DIVU, 32'd5, 32'd0, 1'b0, lat, stl, res);
      checks++; if (res !== 32'hFFFF_FFFF || lat !== 1) begin failures++; $display("FAIL divu_by0 got=%h lat=%0d want=ffffffff lat=1", res, lat); end
      step();
      checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin failures++; $display("FAIL divu_by0_idle busy=%0b done=%0b want=0,0", md_busy, md_done); end
      do_op(OP_REM, 32'd5, 32'd0, 1'b0, lat, stl, res);
      checks++; if (res !== 32'd5 || lat !== 1) begin failures++; $display("FAIL rem_by0 got=%h lat=%0d want=00000005 lat=1", res, lat); end
      step();
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, stl, res);
      checks++; if (res !== 32'h8000_0000 || lat !== 1) begin failures++; $display("FAIL div_ovf got=%h lat=%0d want=80000000 lat=1", res, lat); end
      step();
      do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, stl, res);
      checks++; if (res !== 32'h0 || lat !== 1) begin failures++; $display("FAIL rem_ovf got=%h lat=%0d want=00000000 lat=1", res, lat); end
      step();
      do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, stl, res);
      checks++; if (res !== 32'h0 || lat !== 33) begin failures++; $display("FAIL divu_nospecial got=%h lat=%0d want=00000000 lat=33", res, lat); end
      step();
   endtask

   task automatic test_back_to_back();
      int lat, stl; logic [31:0] res;
      do_op(OP_MULHU, 32'h0001_0000, 32'h0003_0000, 1'b0, lat, stl, res);
      checks++; if (res !== 32'd3) begin failures++; $display("FAIL b2b_first got=%h want=00000003", res); end
      step();
      do_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat, stl, res);
      checks++; if (res !== 32'd14 || lat !== 33) begin failures++; $display("FAIL b2b_second got=%h lat=%0d want=0000000e lat=33", res, lat); end
      step();
   endtask

   task automatic test_flush();
      int dones = 0;
      md_op = OP_DIVU; md_s1 = 32'd1000; md_s2 = 32'd3; md_start = 1'b1;
      step();
      md_start = 1'b0;
      for (int k = 0; k < 9; k++) step();
      md_flush = 1'b1;
      step();
      md_flush = 1'b0;
      #1;
      checks++; if (md_busy !== 1'b0 || md_stall !== 1'b0 || md_done !== 1'b0) begin failures++; $display("FAIL flush_idle busy=%0b stall=%0b done=%0b want=0,0,0", md_busy, md_stall, md_done); end
      checks++; if (md_result !== 32'd14) begin failures++; $display("FAIL flush_result got=%h want=0000000e", md_result); end
      for (int k = 0; k < 40; k++) begin
         step();
         if (md_done) dones++;
      end
      checks++; if (dones !== 0) begin failures++; $display("FAIL flush_no_done got=%0d want=0", dones); end
   endtask

   task automatic test_async_reset();
      int lat, stl, dones = 0; logic [31:0] res;
      md_op = OP_MUL; md_s1 = 32'd5; md_s2 = 32'd5; md_start = 1'b1;
      step();
      md_start = 1'b0;
      for (int k = 0; k < 4; k++) step();
      #2 rst = 1'b1;
      #1;
      checks++; if (md_busy !== 1'b0 || md_stall !== 1'b0 || md_done !== 1'b0) begin failures++; $display("FAIL arst_ctrl busy=%0b stall=%0b done=%0b want=0,0,0", md_busy, md_stall, md_done); end
      checks++; if (md_result !== 32'h0) begin failures++; $display("FAIL arst_result got=%h want=0", md_result); end
      #2 rst = 1'b0;
      step();
      for (int k = 0; k < 40; k++) begin
         if (md_done) dones++;
         step();
      end
      checks++; if (dones !== 0) begin failures++; $display("FAIL arst_no_done got=%0d want=0", dones); end
      do_op(OP_MUL, 32'd3, 32'd3, 1'b0, lat, stl, res);
      checks++; if (res !== 32'd9 || lat !== 33) begin failures++; $display("FAIL arst_mul3x3 got=%h lat=%0d want=00000009 lat=33", res, lat); end
      step();
   endtask

   task automatic test_start_ignored();
      int lat, stl; logic [31:0] res;
      do_op(OP_MUL, 32'd7, 32'd6, 1'b1, lat, stl, res);
      checks++; if (res !== 32'd42 || lat !== 33) begin failures++; $display("FAIL start_held got=%h lat=%0d want=0000002a lat=33", res, lat); end
      step();
      checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL start_held_idle busy=%0b want=0", md_busy); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_special();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_start_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
